// File: rtl/onchip_ram_stream_reader_pkg.sv
// Shared types and constants for the on-chip RAM stream reader.
//   state_e    : transfer FSM states (IDLE -> READ -> DRAIN -> DONE)
//   ADDR_W_DEF : default RAM word-address width (16K words)
//   DATA_W_DEF : default data width
//   BE_ALL     : byte-enable value driven for every read
package onchip_ram_reader_pkg;

  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned DATA_W_DEF = 32;
  localparam logic [3:0]  BE_ALL     = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/onchip_ram_stream_fifo.sv
// Synchronous show-ahead FIFO; the head word is visible on rd_data_o whenever
// empty_o is low. flush_i empties the FIFO and wins over read and write.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : discard all contents
//   wr_en_i    : push wr_data_i (ignored when full and not popping)
//   rd_en_i    : pop the head word (ignored when empty)
//   rd_data_o  : head word
//   empty_o    : no words stored
//   count_o    : number of words stored, 0..DEPTH
module onchip_ram_stream_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, do_wr, do_rd;

  assign empty_o   = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  // Storage has no reset; unwritten entries are never visible because
  // the count gates validity.
  always_ff @(posedge clk) begin
    if (do_wr && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/onchip_ram_stream_reader.sv
// Avalon-MM read master that drains a block of words from a fixed-latency,
// no-waitrequest on-chip RAM and presents them as an Avalon-ST source with
// valid/ready backpressure and sop/eop packet markers.
//   clk, reset_n            : clock, asynchronous active-low reset
//   start, start_addr,length: begin a transfer (accepted only when idle)
//   abort                   : cancel the current transfer
//   busy, done              : transfer in progress / one-cycle completion pulse
//   m_address, m_chipselect,
//   m_byteenable, m_clken,
//   m_readdata              : RAM read port
//   st_data, st_valid,
//   st_ready, st_sop, st_eop: stream source
module onchip_ram_stream_reader
  import onchip_ram_reader_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic [3:0]        m_byteenable,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [ADDR_W:0]         issue_cnt_q, issue_cnt_d;
  logic [ADDR_W:0]         out_cnt_q, out_cnt_d;
  logic [ADDR_W:0]         len_q, len_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic                    aborting_q, aborting_d;

  logic                    abort_now, issue, capture, beat;
  logic                    fifo_wr, fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic [DATA_W-1:0]       fifo_head;
  int unsigned             occupancy;

  // Credit: reads still in the RAM pipeline plus words already buffered must
  // leave room for one more, so the FIFO can never overflow.
  always_comb begin
    occupancy = 32'(fifo_count);
    for (int unsigned i = 0; i < READ_LATENCY; i++) begin
      occupancy = occupancy + 32'(vld_q[i]);
    end
  end

  assign abort_now = abort && (state_q == S_READ || state_q == S_DRAIN);
  assign issue     = (state_q == S_READ) && !abort_now &&
                     (issue_cnt_q != '0) && (occupancy < FIFO_DEPTH);
  assign capture   = vld_q[READ_LATENCY-1];
  assign fifo_wr   = capture && !abort_now && !aborting_q;
  assign beat      = st_valid && st_ready;

  // In-flight tracker: bit k set means a read issued k+1 cycles ago.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue;
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    len_d       = len_q;
    aborting_d  = aborting_q;

    if (beat) out_cnt_d = out_cnt_q - CNT_ONE;
    if (issue) begin
      addr_d      = addr_q + ADDR_W'(1);
      issue_cnt_d = issue_cnt_q - CNT_ONE;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d = length;
          if (length != '0) begin
            addr_d      = start_addr;
            issue_cnt_d = length;
            out_cnt_d   = length;
            state_d     = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        if (abort_now) begin
          aborting_d = 1'b1;
          state_d    = (vld_d == '0) ? S_DONE : S_DRAIN;
        end else if (issue && issue_cnt_q == CNT_ONE) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Aborted transfers wait only for outstanding reads to retire;
        // normal ones finish in the cycle the final beat is accepted.
        if (abort_now || aborting_q) begin
          aborting_d = 1'b1;
          if (vld_d == '0) begin
            aborting_d = 1'b0;
            state_d    = S_DONE;
          end
        end else if (out_cnt_q == '0 || (out_cnt_q == CNT_ONE && beat)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        aborting_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      len_q       <= '0;
      vld_q       <= '0;
      aborting_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      len_q       <= len_d;
      vld_q       <= vld_d;
      aborting_q  <= aborting_d;
    end
  end

  onchip_ram_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .flush_i   (abort_now),
    .wr_en_i   (fifo_wr),
    .wr_data_i (m_readdata),
    .rd_en_i   (beat),
    .rd_data_o (fifo_head),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign busy         = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign m_address    = addr_q;
  assign m_chipselect = issue;
  assign m_byteenable = BE_ALL;
  assign m_clken      = 1'b1;

  // Packet markers derive from the remaining-beat counter, which only moves
  // on an accepted beat, so they hold steady under backpressure.
  assign st_valid = !fifo_empty;
  assign st_data  = st_valid ? fifo_head : '0;
  assign st_sop   = st_valid && (out_cnt_q == len_q);
  assign st_eop   = st_valid && (out_cnt_q == CNT_ONE);

endmodule

// File: tb/tb_onchip_ram_stream_reader.sv
module tb_onchip_ram_stream_reader;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RL = 1;

  logic          clk, reset_n, start, abort, busy, done;
  logic [AW-1:0] start_addr, m_address;
  logic [AW:0]   length;
  logic          m_chipselect, m_clken, st_valid, st_ready, st_sop, st_eop;
  logic [3:0]    m_byteenable;
  logic [DW-1:0] m_readdata, st_data, ram_rdata;

  logic [DW-1:0] ram [1 << AW];

  int errors = 0;
  int checks = 0;

  logic [DW+1:0] exp_q[$];
  logic [AW-1:0] addr_exp_q[$];
  int beats_n, cs_n, done_n, issued_n, popped_n;
  int unsigned ready_pct = 100;
  bit ready_manual = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW:0]   len;
    int unsigned   pct;
    int            exp_beats;
    int            exp_cs;
  } vec_t;
  vec_t vecs[7];

  onchip_ram_stream_reader #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .READ_LATENCY (RL),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .start_addr   (start_addr),
    .length       (length),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_byteenable (m_byteenable),
    .m_clken      (m_clken),
    .m_readdata   (m_readdata),
    .st_data      (st_data),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_sop       (st_sop),
    .st_eop       (st_eop)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // RAM model: one-cycle read latency, no waitrequest.
  always_ff @(posedge clk) begin
    if (m_chipselect) ram_rdata <= ram[m_address];
  end
  assign m_readdata = ram_rdata;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_reset_outs(input string name);
    check(name, {busy, done, m_chipselect, st_valid, st_sop, st_eop, m_address, st_data, m_byteenable, m_clken},
          {6'b0, 14'd0, 32'd0, 4'hF, 1'b1});
  endtask

  // Random sink readiness, unless the main sequence drives st_ready itself.
  initial begin
    st_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!ready_manual)
        st_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor and scoreboard.
  initial begin
    logic          stall_prev = 0;
    logic          abort_prev = 0;
    logic [DW+2:0] prev_beat = '0;
    logic [DW+1:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall_prev = 0;
        abort_prev = 0;
      end else begin
        if (stall_prev && !abort_prev)
          check("stall_hold", {st_valid, st_data, st_sop, st_eop}, prev_beat);
        stall_prev = st_valid && !st_ready;
        prev_beat  = {st_valid, st_data, st_sop, st_eop};
        abort_prev = abort;
        if (m_chipselect) begin
          check("credit", 64'(issued_n - popped_n + 1 <= int'(DEPTH)), 64'd1);
          if (addr_exp_q.size() == 0) check("extra_chipselect", 64'(m_address), 64'hFFFF);
          else check("m_address", 64'(m_address), 64'(addr_exp_q.pop_front()));
          issued_n++;
          cs_n++;
        end
        if (st_valid && st_ready) begin
          if (exp_q.size() == 0) check("extra_beat", 64'(st_data), 64'hFFFF_FFFF_F);
          else begin
            e = exp_q.pop_front();
            check("beat", {st_data, st_sop, st_eop}, 64'(e));
          end
          popped_n++;
          beats_n++;
        end
        if (done) done_n++;
      end
    end
  end

  task automatic start_xfer(input logic [AW-1:0] addr, input logic [AW:0] len);
    exp_q.delete();
    addr_exp_q.delete();
    beats_n = 0; cs_n = 0; done_n = 0; issued_n = 0; popped_n = 0;
    for (int i = 0; i < int'(len); i++) begin
      logic [AW-1:0] a;
      a = AW'(int'(addr) + i);
      addr_exp_q.push_back(a);
      exp_q.push_back({ram[a], 1'(i == 0), 1'(i == int'(len) - 1)});
    end
    start = 1; start_addr = addr; length = len;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    bit ok;
    ready_pct = v.pct;
    @(posedge clk); #1;
    start_xfer(v.addr, v.len);
    wait_done(3000, ok);
    check({tag, "_done_seen"}, 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
    check({tag, "_beats"}, 64'(beats_n), 64'(v.exp_beats));
    check({tag, "_chipselects"}, 64'(cs_n), 64'(v.exp_cs));
    check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_done_pulses"}, 64'(done_n), 64'd1);
    check({tag, "_idle_after"}, {busy, st_valid}, 2'b00);
  endtask

  initial begin
    int  first_cs, first_v, last_v, done_c, cs_at_abort, done_at;
    bit  ok;
    reset_n = 0; start = 0; abort = 0; start_addr = '0; length = '0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h5A00_0000 ^ 32'(i);

    vecs[0] = '{addr: 14'd100,   len: 15'd8,  pct: 100, exp_beats: 8,  exp_cs: 8};
    vecs[1] = '{addr: 14'd16382, len: 15'd4,  pct: 100, exp_beats: 4,  exp_cs: 4};
    vecs[2] = '{addr: 14'd500,   len: 15'd32, pct: 30,  exp_beats: 32, exp_cs: 32};
    vecs[3] = '{addr: 14'd7,     len: 15'd0,  pct: 100, exp_beats: 0,  exp_cs: 0};
    vecs[4] = '{addr: 14'd9000,  len: 15'd1,  pct: 100, exp_beats: 1,  exp_cs: 1};
    vecs[5] = '{addr: 14'd16000, len: 15'd40, pct: 60,  exp_beats: 40, exp_cs: 40};
    vecs[6] = '{addr: 14'd16380, len: 15'd9,  pct: 15,  exp_beats: 9,  exp_cs: 9};

    repeat (3) @(posedge clk);
    #1 check_reset_outs("reset_state");
    reset_n = 1;

    // Latency and throughput with the sink always ready.
    ready_pct = 100;
    @(posedge clk); #1;
    start_xfer(14'd100, 15'd8);
    first_cs = 0; first_v = 0; last_v = 0; done_c = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (m_chipselect && first_cs == 0) first_cs = k;
      if (st_valid && st_ready) begin
        if (first_v == 0) first_v = k;
        last_v = k;
      end
      if (done && done_c == 0) done_c = k;
    end
    check("lat_first_cs", 64'(first_cs), 64'd1);
    check("lat_first_valid", 64'(first_v), 64'd3);
    check("lat_last_beat", 64'(last_v), 64'd10);
    check("lat_done", 64'(done_c), 64'd11);
    check("lat_beats", 64'(beats_n), 64'd8);

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Abort with the sink stalled on beat 10.
    ready_manual = 1;
    @(posedge clk); #1;
    st_ready = 1;
    start_xfer(14'd2000, 15'd64);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #2;
      if (beats_n >= 9) begin ok = 1; break; end
    end
    check("abort_reached_beat9", 64'(ok), 64'd1);
    st_ready = 0;
    abort = 1;
    cs_at_abort = cs_n;
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    check("abort_valid_drop", 64'(st_valid), 64'd0);
    done_at = 0;
    for (int k = 1; k <= int'(RL) + 2; k++) begin
      if (k > 1) @(negedge clk);
      if (done && done_at == 0) done_at = k;
    end
    check("abort_done_in_time", 64'(done_at != 0), 64'd1);
    repeat (3) @(negedge clk);
    check("abort_no_more_cs", 64'(cs_n), 64'(cs_at_abort));
    check("abort_beats", 64'(beats_n), 64'd9);
    check("abort_done_pulses", 64'(done_n), 64'd1);
    ready_manual = 0;
    run_vec("post_abort", '{addr: 14'd300, len: 15'd5, pct: 100, exp_beats: 5, exp_cs: 5});

    // Asynchronous reset in the middle of a transfer.
    ready_pct = 100;
    @(posedge clk); #1;
    start_xfer(14'd1000, 15'd20);
    repeat (3) @(posedge clk);
    #1 check("busy_pre_reset", 64'(busy), 64'd1);
    #2 reset_n = 0;
    #1 check_reset_outs("reset_mid_xfer");
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    run_vec("post_reset", '{addr: 14'd1200, len: 15'd6, pct: 50, exp_beats: 6, exp_cs: 6});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
